// File: rtl/net_packet_receiver_pkg.sv
// Shared net-packet definitions: packet layout, op codes, instruction word and receiver states.
`default_nettype none

package net_packet_receiver_pkg;

    localparam int net_id_width_gp       = 10;
    localparam int net_addr_width_gp     = 10;
    localparam int net_reserved_width_gp = 5;
    localparam int mask_length_gp        = 3;
    localparam int rs_imm_size_gp        = 6;

    typedef enum logic [2:0] {
        NET_NULL  = 3'd0,
        NET_INSTR = 3'd1,
        NET_REG   = 3'd2,
        NET_PC    = 3'd3,
        NET_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs_imm;
    } instruction_s;

    typedef struct packed {
        logic [net_id_width_gp-1:0]       id;
        net_op_e                          net_op;
        logic [net_reserved_width_gp-1:0] reserved;
        logic [31:0]                      net_data;
        logic [net_addr_width_gp-1:0]     net_addr;
    } net_packet_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/net_packet_checker.sv
// Combinational field validation of an incoming net packet (ID match, op, reserved, ranges).
`default_nettype none

import net_packet_receiver_pkg::*;

module net_packet_checker #(
    parameter logic [net_id_width_gp-1:0] core_id_p = 10'd1
) (
    input  logic [net_id_width_gp-1:0]                  id_i,
    input  net_op_e                                     op_i,
    input  logic [net_reserved_width_gp-1:0]            reserved_i,
    input  logic [15:0]                                 data_hi_i,
    input  logic [net_addr_width_gp-rs_imm_size_gp-1:0] addr_hi_i,
    output logic                                        addressed_o,
    output logic                                        null_op_o,
    output logic                                        op_known_o,
    output logic                                        reserved_ok_o,
    output logic                                        instr_data_ok_o,
    output logic                                        reg_addr_ok_o
);

    assign addressed_o     = (id_i == core_id_p);
    assign null_op_o       = (op_i == NET_NULL);
    assign reserved_ok_o   = (reserved_i == '0);
    assign instr_data_ok_o = (data_hi_i == 16'h0000);
    assign reg_addr_ok_o   = (addr_hi_i == '0);

    always_comb begin
        op_known_o = 1'b0;
        case (op_i)
            NET_INSTR, NET_REG, NET_PC, NET_BAR: op_known_o = 1'b1;
            default:                             op_known_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/net_packet_receiver.sv
// Net packet receiver: loads instruction memory, register file, barrier mask and PC from packets.
`default_nettype none

import net_packet_receiver_pkg::*;

module net_packet_receiver #(
    parameter logic [net_id_width_gp-1:0] core_id_p         = 10'd1,
    parameter int                         imem_addr_width_p = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [$bits(net_packet_s)-1:0]     net_packet_flat_i,
    output logic                               imem_wen_o,
    output logic [imem_addr_width_p-1:0]       imem_addr_o,
    output logic [$bits(instruction_s)-1:0]    imem_data_o,
    output logic                               rf_wen_o,
    output logic [rs_imm_size_gp-1:0]          rf_addr_o,
    output logic [31:0]                        rf_data_o,
    output logic [mask_length_gp-1:0]          barrier_mask_o,
    output logic                               pc_wen_o,
    output logic [imem_addr_width_p-1:0]       pc_o,
    output logic                               run_o,
    output logic [15:0]                        pkt_count_o,
    output logic                               error_o
);

    net_packet_s pkt;
    rx_state_e   state;
    logic        armed;
    logic        addressed;
    logic        null_op;
    logic        op_known;
    logic        reserved_ok;
    logic        instr_data_ok;
    logic        reg_addr_ok;

    assign pkt = net_packet_flat_i;

    net_packet_checker #(
        .core_id_p (core_id_p)
    ) u_checker (
        .id_i            (pkt.id),
        .op_i            (pkt.net_op),
        .reserved_i      (pkt.reserved),
        .data_hi_i       (pkt.net_data[31:16]),
        .addr_hi_i       (pkt.net_addr[net_addr_width_gp-1:rs_imm_size_gp]),
        .addressed_o     (addressed),
        .null_op_o       (null_op),
        .op_known_o      (op_known),
        .reserved_ok_o   (reserved_ok),
        .instr_data_ok_o (instr_data_ok),
        .reg_addr_ok_o   (reg_addr_ok)
    );

    // armed stays low for the first edge after reset release so a packet
    // straddling the release is never acted upon.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            armed          <= 1'b0;
            imem_wen_o     <= 1'b0;
            imem_addr_o    <= '0;
            imem_data_o    <= '0;
            rf_wen_o       <= 1'b0;
            rf_addr_o      <= '0;
            rf_data_o      <= '0;
            barrier_mask_o <= '0;
            pc_wen_o       <= 1'b0;
            pc_o           <= '0;
            run_o          <= 1'b0;
            pkt_count_o    <= '0;
            error_o        <= 1'b0;
        end else begin
            armed      <= 1'b1;
            imem_wen_o <= 1'b0;
            rf_wen_o   <= 1'b0;
            pc_wen_o   <= 1'b0;
            if (armed && addressed && !null_op) begin
                if (!reserved_ok || !op_known) begin
                    error_o <= 1'b1;
                end else begin
                    case (pkt.net_op)
                        NET_INSTR: begin
                            // Loads are refused once running; wide data is a protocol error.
                            if (state == ST_RUN || !instr_data_ok) begin
                                error_o <= 1'b1;
                            end else begin
                                imem_wen_o  <= 1'b1;
                                imem_addr_o <= pkt.net_addr[imem_addr_width_p-1:0];
                                imem_data_o <= pkt.net_data[15:0];
                                state       <= ST_LOAD;
                                pkt_count_o <= sat_inc16(pkt_count_o);
                            end
                        end
                        NET_REG: begin
                            if (state == ST_RUN || !reg_addr_ok) begin
                                error_o <= 1'b1;
                            end else begin
                                rf_wen_o    <= 1'b1;
                                rf_addr_o   <= pkt.net_addr[rs_imm_size_gp-1:0];
                                rf_data_o   <= pkt.net_data;
                                state       <= ST_LOAD;
                                pkt_count_o <= sat_inc16(pkt_count_o);
                            end
                        end
                        NET_BAR: begin
                            barrier_mask_o <= pkt.net_data[mask_length_gp-1:0];
                            if (state != ST_RUN) begin
                                state <= ST_LOAD;
                            end
                            pkt_count_o <= sat_inc16(pkt_count_o);
                        end
                        NET_PC: begin
                            pc_wen_o    <= 1'b1;
                            pc_o        <= pkt.net_data[imem_addr_width_p-1:0];
                            state       <= ST_RUN;
                            run_o       <= 1'b1;
                            pkt_count_o <= sat_inc16(pkt_count_o);
                        end
                        default: error_o <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_net_packet_receiver.sv
// Scoreboard bench for net_packet_receiver: directed scenarios plus randomized packet stream.
`default_nettype none

module tb_net_packet_receiver;
    import net_packet_receiver_pkg::*;

    localparam logic [9:0] CORE = 10'd1;

    logic                            clk = 1'b0;
    logic                            reset = 1'b1;
    logic [$bits(net_packet_s)-1:0]  net_packet_flat_i = '0;
    logic                            imem_wen_o;
    logic [9:0]                      imem_addr_o;
    logic [15:0]                     imem_data_o;
    logic                            rf_wen_o;
    logic [5:0]                      rf_addr_o;
    logic [31:0]                     rf_data_o;
    logic [2:0]                      barrier_mask_o;
    logic                            pc_wen_o;
    logic [9:0]                      pc_o;
    logic                            run_o;
    logic [15:0]                     pkt_count_o;
    logic                            error_o;

    net_packet_receiver #(.core_id_p(CORE), .imem_addr_width_p(10)) dut (
        .clk(clk), .reset(reset), .net_packet_flat_i(net_packet_flat_i),
        .imem_wen_o(imem_wen_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .rf_wen_o(rf_wen_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
        .barrier_mask_o(barrier_mask_o), .pc_wen_o(pc_wen_o), .pc_o(pc_o),
        .run_o(run_o), .pkt_count_o(pkt_count_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: kind 1 = imem write, 2 = rf write, 3 = pc load.
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    bit          m_armed, m_run, m_err;
    logic [15:0] m_cnt;
    logic [2:0]  m_mask;

    task automatic model_clear();
        m_armed = 0; m_run = 0; m_err = 0; m_cnt = 16'd0; m_mask = 3'd0;
        expq.delete();
    endtask

    task automatic accept();
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_step(input net_packet_s p);
        int op;
        exp_t e;
        op = int'(p.net_op);
        if (!m_armed) begin
            m_armed = 1;
            return;
        end
        if (p.id != CORE || op == 0) return;
        if (p.reserved != 0 || op > 4) begin
            m_err = 1;
            return;
        end
        if (op == 1) begin
            if (m_run || p.net_data[31:16] != 16'h0) m_err = 1;
            else begin
                e.kind = 1; e.addr = 32'(p.net_addr); e.data = 32'(p.net_data[15:0]);
                expq.push_back(e); accept();
            end
        end else if (op == 2) begin
            if (m_run || p.net_addr > 10'd63) m_err = 1;
            else begin
                e.kind = 2; e.addr = 32'(p.net_addr); e.data = p.net_data;
                expq.push_back(e); accept();
            end
        end else if (op == 3) begin
            e.kind = 3; e.addr = 32'd0; e.data = 32'(p.net_data[9:0]);
            expq.push_back(e); accept();
            m_run = 1;
        end else begin
            m_mask = p.net_data[2:0];
            accept();
        end
    endtask

    initial model_clear();
    initial forever begin
        @(posedge clk);
        if (reset) model_clear();
        else model_step(net_packet_flat_i);
    end
    initial forever begin
        @(posedge reset);
        model_clear();
    end

    // Monitor: pops one expectation per observed strobe, compares held state too.
    initial forever begin
        int   nstb;
        int   kind;
        exp_t e;
        @(negedge clk);
        nstb = int'(imem_wen_o) + int'(rf_wen_o) + int'(pc_wen_o);
        check("one_hot_strobe", 32'(nstb <= 1), 32'd1);
        if (nstb != 0) begin
            kind = imem_wen_o ? 1 : (rf_wen_o ? 2 : 3);
            if (expq.size() == 0) begin
                check("unexpected_strobe_kind", 32'(kind), 32'd0);
            end else begin
                e = expq.pop_front();
                check("strobe_kind", 32'(kind), 32'(e.kind));
                if (kind == 1) begin
                    check("imem_addr", 32'(imem_addr_o), e.addr);
                    check("imem_data", 32'(imem_data_o), e.data);
                end else if (kind == 2) begin
                    check("rf_addr", 32'(rf_addr_o), e.addr);
                    check("rf_data", rf_data_o, e.data);
                end else begin
                    check("pc_value", 32'(pc_o), e.data);
                end
            end
        end else if (expq.size() != 0) begin
            e = expq.pop_front();
            check("missing_strobe_kind", 32'd0, 32'(e.kind));
        end
        check("error_flag", 32'(error_o), 32'(m_err));
        check("pkt_count", 32'(pkt_count_o), 32'(m_cnt));
        check("barrier_mask", 32'(barrier_mask_o), 32'(m_mask));
        check("run_flag", 32'(run_o), 32'(m_run));
    end

    task automatic send(input logic [9:0] id, input logic [2:0] op, input logic [4:0] rsv,
                        input logic [31:0] data, input logic [9:0] addr);
        net_packet_s p;
        p.id = id; p.net_op = net_op_e'(op); p.reserved = rsv;
        p.net_data = data; p.net_addr = addr;
        net_packet_flat_i = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(10'd0, 3'd0, 5'd0, 32'd0, 10'd0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_wen"}, 32'(imem_wen_o), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr_o), 32'd0);
        check({tag, "_imem_data"}, 32'(imem_data_o), 32'd0);
        check({tag, "_rf_wen"}, 32'(rf_wen_o), 32'd0);
        check({tag, "_rf_data"}, rf_data_o, 32'd0);
        check({tag, "_mask"}, 32'(barrier_mask_o), 32'd0);
        check({tag, "_pc"}, 32'(pc_o), 32'd0);
        check({tag, "_pc_wen"}, 32'(pc_wen_o), 32'd0);
        check({tag, "_run"}, 32'(run_o), 32'd0);
        check({tag, "_count"}, 32'(pkt_count_o), 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Foreign IDs and NULL packets are ignored silently.
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) send(10'd2, 3'd1, 5'd0, $urandom, 10'(i));
            else            send(CORE, 3'd0, 5'd0, $urandom, 10'($urandom));
        end
        check("foreign_count", 32'(pkt_count_o), 32'd0);
        check("foreign_error", 32'(error_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            send(CORE, 3'd1, 5'd0, 32'h1234 + 32'(i), 10'(i));
            check("load_imem_wen", 32'(imem_wen_o), 32'd1);
            check("load_imem_data", 32'(imem_data_o), 32'h1234 + 32'(i));
        end
        check("load_count", 32'(pkt_count_o), 32'd4);
        check("load_not_run", 32'(run_o), 32'd0);

        send(CORE, 3'd2, 5'd0, 32'hDEADBEEF, 10'd63);
        check("reg63_wen", 32'(rf_wen_o), 32'd1);
        check("reg63_addr", 32'(rf_addr_o), 32'd63);
        send(CORE, 3'd2, 5'd0, 32'h11111111, 10'd64);
        check("reg64_wen", 32'(rf_wen_o), 32'd0);
        check("reg64_error", 32'(error_o), 32'd1);

        send(CORE, 3'd4, 5'd0, 32'h2, 10'd0);
        check("bar_mask", 32'(barrier_mask_o), 32'd2);
        send(CORE, 3'd3, 5'd0, 32'h5, 10'd0);
        check("pc5_wen", 32'(pc_wen_o), 32'd1);
        check("pc5_value", 32'(pc_o), 32'd5);
        idle(1);
        check("pc5_single_pulse", 32'(pc_wen_o), 32'd0);
        check("pc5_run", 32'(run_o), 32'd1);

        send(CORE, 3'd1, 5'd0, 32'h7, 10'd1);
        check("run_instr_wen", 32'(imem_wen_o), 32'd0);
        check("run_instr_error", 32'(error_o), 32'd1);
        send(CORE, 3'd3, 5'd0, 32'h0, 10'd0);
        check("pc0_wen", 32'(pc_wen_o), 32'd1);
        check("pc0_value", 32'(pc_o), 32'd0);

        // Reset in the middle of an INSTR stream, with a strobe pending.
        do_reset();
        idle(1);
        for (int i = 0; i < 3; i++) send(CORE, 3'd1, 5'd0, 32'h50 + 32'(i), 10'(i));
        #1 reset = 1'b1;
        #1 check_all_zero("midreset");
        net_packet_flat_i = '0;
        @(posedge clk);
        net_packet_flat_i = {CORE, NET_INSTR, 5'd0, 32'h99, 10'd9};
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_pkt_ignored", 32'(imem_wen_o), 32'd0);
        check("release_count", 32'(pkt_count_o), 32'd0);
        send(CORE, 3'd1, 5'd0, 32'h42, 10'd5);
        check("post_reset_wen", 32'(imem_wen_o), 32'd1);
        check("post_reset_addr", 32'(imem_addr_o), 32'd5);
        check("post_reset_count", 32'(pkt_count_o), 32'd1);

        // Randomized stream checked by the scoreboard.
        for (int i = 0; i < 800; i++) begin
            logic [9:0]  id;
            logic [2:0]  op;
            logic [4:0]  rsv;
            logic [31:0] data;
            id   = ($urandom_range(0, 3) == 0) ? 10'(2 + $urandom_range(0, 5)) : CORE;
            op   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            if (op == 3'd3 && $urandom_range(0, 3) != 0) op = 3'd1;
            rsv  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            data = $urandom;
            if ($urandom_range(0, 3) != 0) data[31:16] = 16'h0;
            send(id, op, rsv, data, 10'($urandom_range(0, 80)));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/net_packet_receiver.md
NET_PACKET_RECEIVER -- requirements
Module: net_packet_receiver

Interface
REQ-001 SHALL have parameter core_id_p, default 10'd1, the net packet ID this core accepts.
REQ-002 SHALL have parameter imem_addr_width_p, default 10, the instruction-memory address width (1024 entries).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 net_packet_flat_i  input  $bits(net_packet_s)  incoming packet {ID, net_op, reserved, net_data, net_addr}, registered upstream, new value each cycle.
REQ-007 imem_wen_o / imem_addr_o / imem_data_o  output  1 / imem_addr_width_p / $bits(instruction_s)  instruction write.
REQ-008 rf_wen_o / rf_addr_o / rf_data_o  output  1 / rs_imm_size_gp / 32  register-file write.
REQ-009 barrier_mask_o  output  mask_length_gp  held barrier mask.
REQ-010 pc_wen_o / pc_o  output  1 / imem_addr_width_p  PC load request.
REQ-011 run_o  output  1  high while in RUN.
REQ-012 pkt_count_o  output  16  count of accepted packets.
REQ-013 error_o  output  1  sticky protocol-error flag.

Function
REQ-014 Packet SHALL be addressed to this core iff ID == core_id_p; other IDs and net_op NULL SHALL be ignored silently (no strobe, no count, no error).
REQ-015 Every write strobe SHALL be registered: packet present at edge N -> strobe, address and data valid for exactly the cycle after edge N; strobes SHALL be single-cycle per packet.
REQ-016 INSTR: imem_addr_o = net_addr[imem_addr_width_p-1:0], imem_data_o = net_data[15:0]; net_data[31:16] != 0 -> error.
REQ-017 REG: rf_addr_o = net_addr[rs_imm_size_gp-1:0], rf_data_o = net_data; net_addr bits above rs_imm_size_gp nonzero -> packet dropped, error set.
REQ-018 BAR: barrier_mask_o <= net_data[mask_length_gp-1:0], held until next BAR or reset.
REQ-019 PC: pc_o = net_data[imem_addr_width_p-1:0], pc_wen_o pulses one cycle; state -> RUN.
REQ-020 Nonzero reserved field or undefined net_op on an addressed packet SHALL drop the packet and set error_o.
REQ-021 States: IDLE (after reset), LOAD (after first accepted INSTR/REG/BAR), RUN (after PC); IDLE/LOAD -> RUN on PC; RUN -> RUN on PC (restart, pc_wen_o pulses again).
REQ-022 In RUN, INSTR and REG packets SHALL be dropped with error_o set; BAR SHALL still be accepted.
REQ-023 pkt_count_o SHALL increment by 1 per accepted (non-dropped) packet, saturating at 16'hFFFF.
REQ-024 error_o SHALL remain set until reset; it SHALL not block later valid packets.
REQ-025 At most one strobe (imem_wen_o, rf_wen_o, pc_wen_o) SHALL be high in any cycle.

Reset
REQ-026 On reset assertion all outputs SHALL clear immediately: strobes 0, addresses/data 0, barrier_mask_o 0, pc_o 0, run_o 0, pkt_count_o 0, error_o 0, state IDLE.
REQ-027 A packet present during the cycle reset deasserts SHALL be ignored; a strobe pending when reset asserts SHALL be suppressed.

Structure
REQ-028 net_packet_s, net_op enum, instruction_s, mask_length_gp and rs_imm_size_gp SHALL come from the shared definitions package; the state enum SHALL also live there.
REQ-029 Field validation (ID match, reserved check, address range) SHALL be one combinational sub-module, net_packet_checker.

Verification
REQ-030 Load: INSTR addr 0..3 data 16'h1234..16'h1237 -> four imem_wen_o pulses, one cycle after each packet, matching addr/data; pkt_count_o = 4; state LOAD.
REQ-031 REG addr 6'd63 data 32'hDEADBEEF -> rf_wen_o pulse, rf_addr_o 63; REG net_addr 10'd64 -> no strobe, error_o = 1.
REQ-032 BAR data 32'h2 then PC data 32'h5 -> barrier_mask_o = 2, pc_wen_o one pulse with pc_o = 5, run_o = 1 next cycle.
REQ-033 In RUN, INSTR packet -> no imem_wen_o, error_o = 1; following PC data 0 -> pc_wen_o pulse, pc_o = 0.
REQ-034 ID 10'd2 and NULL packets streamed 100 cycles -> no strobes, pkt_count_o unchanged, error_o = 0.
REQ-035 Reset asserted mid-stream of INSTR packets -> all outputs 0 within same cycle; after release, first new packet strobes normally and pkt_count_o = 1.
